// File: rtl/board_array_if.sv
// Landing-piece handshake and board status bundle between the falling-piece
// generator (master) and the board array (slave).
interface board_array_if;
  logic             bottom_flag;
  logic             top_flag;
  logic             Ack;
  logic [3:0]       x1, y1, x2, y2, x3, y3, x4, y4;
  logic [9:0][11:0] arr;
  logic             gen_flag;
  logic             game_over;
  logic [7:0]       lines;
  logic [6:0]       state;

  modport master (
    output bottom_flag, top_flag, Ack, x1, y1, x2, y2, x3, y3, x4, y4,
    input  arr, gen_flag, game_over, lines, state
  );

  modport slave (
    input  bottom_flag, top_flag, Ack, x1, y1, x2, y2, x3, y3, x4, y4,
    output arr, gen_flag, game_over, lines, state
  );
endinterface

// File: rtl/board_array.sv
// 10x12 playfield: locks landed pieces, scans for full rows bottom-up and
// collapses them, counting cleared lines; one-hot control FSM.
module board_array (
  input  logic         Clk,
  input  logic         Reset,
  board_array_if.slave bus
);
  typedef enum logic [6:0] {
    INI   = 7'b0000001,
    GEN   = 7'b0000010,
    PLAY  = 7'b0000100,
    LOCK  = 7'b0001000,
    SCAN  = 7'b0010000,
    SHIFT = 7'b0100000,
    OVER  = 7'b1000000
  } state_t;

  state_t           r_state;
  logic [9:0][11:0] r_arr;
  logic [7:0]       r_lines;
  logic [3:0]       r_row;
  logic             r_bf_d;

  logic [9:0][11:0] w_lock_arr;
  logic [9:0][11:0] w_shift_arr;
  logic [9:0]       w_row_bits;
  logic             w_row_full;
  logic             w_bf_rise;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Out-of-range coordinates never match any cell, so they are dropped for free.
  for (genvar gx = 0; gx < 10; gx++) begin : g_col
    assign w_row_bits[gx] = r_arr[gx][r_row];
    for (genvar gy = 0; gy < 12; gy++) begin : g_cell
      logic w_hit;
      assign w_hit = (bus.x1 == 4'(gx) && bus.y1 == 4'(gy)) ||
                     (bus.x2 == 4'(gx) && bus.y2 == 4'(gy)) ||
                     (bus.x3 == 4'(gx) && bus.y3 == 4'(gy)) ||
                     (bus.x4 == 4'(gx) && bus.y4 == 4'(gy));
      assign w_lock_arr[gx][gy] = r_arr[gx][gy] | w_hit;
      if (gy < 11) begin : g_mid
        assign w_shift_arr[gx][gy] = (4'(gy) < r_row) ? r_arr[gx][gy] : r_arr[gx][gy+1];
      end else begin : g_top
        assign w_shift_arr[gx][gy] = 1'b0;
      end
    end
  end

  assign w_row_full = &w_row_bits;
  assign w_bf_rise  = bus.bottom_flag & ~r_bf_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= INI;
      r_arr   <= '0;
      r_lines <= '0;
      r_row   <= '0;
      r_bf_d  <= 1'b0;
    end else begin
      r_bf_d <= bus.bottom_flag;
      case (r_state)
        INI: begin
          r_row   <= '0;
          r_state <= GEN;
        end
        GEN: r_state <= PLAY;
        PLAY: if (w_bf_rise) r_state <= LOCK;
        LOCK: begin
          r_arr <= w_lock_arr;
          if (bus.top_flag) begin
            r_state <= OVER;
          end else begin
            r_row   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_row_full)           r_state <= SHIFT;
          else if (r_row == 4'd11)  r_state <= GEN;
          else                      r_row   <= r_row + 4'd1;
        end
        // Row index stays put so the row that just dropped into r is rescanned.
        SHIFT: begin
          r_arr   <= w_shift_arr;
          r_lines <= sat_inc(r_lines);
          r_state <= SCAN;
        end
        OVER: begin
          if (bus.Ack) begin
            r_arr   <= '0;
            r_lines <= '0;
            r_state <= INI;
          end
        end
        default: r_state <= INI;
      endcase
    end
  end

  assign bus.arr       = r_arr;
  assign bus.gen_flag  = (r_state == GEN);
  assign bus.game_over = (r_state == OVER);
  assign bus.lines     = r_lines;
  assign bus.state     = r_state;
endmodule

// File: tb/tb_board_array.sv
// Directed bench for board_array: landings, row clears, game over, held
// bottom_flag and asynchronous reset abort.
module tb_board_array;
  typedef logic [9:0][11:0] board_t;

  localparam logic [6:0] S_INI  = 7'b0000001;
  localparam logic [6:0] S_GEN  = 7'b0000010;
  localparam logic [6:0] S_PLAY = 7'b0000100;
  localparam logic [6:0] S_LOCK = 7'b0001000;
  localparam logic [6:0] S_OVER = 7'b1000000;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  board_array_if bus ();

  board_array u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic board_t put(input board_t b, input int x, input int y);
    board_t t;
    t = b;
    t[x][y] = 1'b1;
    return t;
  endfunction

  task automatic set_cells(input logic [7:0][3:0] c);
    bus.x1 = c[7]; bus.y1 = c[6];
    bus.x2 = c[5]; bus.y2 = c[4];
    bus.x3 = c[3]; bus.y3 = c[2];
    bus.x4 = c[1]; bus.y4 = c[0];
  endtask

  task automatic wait_play(input string tag);
    int k;
    k = 0;
    while (bus.state !== S_PLAY && k < 40) begin
      tick();
      k++;
    end
    chk(tag, bus.state, S_PLAY);
  endtask

  // cyc counts the raising cycle as 1; returns the cycle in which gen_flag is high.
  task automatic land(input string tag, input logic [7:0][3:0] c, input bit hold,
                      output int cyc, output board_t arr_l);
    wait_play({tag, "_play"});
    set_cells(c);
    bus.top_flag    = 1'b0;
    bus.bottom_flag = 1'b1;
    cyc = 1;
    tick(); cyc++;
    chk({tag, "_lock"}, bus.state, S_LOCK);
    tick(); cyc++;
    arr_l = bus.arr;
    if (!hold) bus.bottom_flag = 1'b0;
    while (bus.gen_flag !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    board_t exp_b;
    board_t lock_b;
    int     cyc;

    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.bottom_flag = 1'b0;
    bus.top_flag    = 1'b0;
    bus.Ack         = 1'b0;
    set_cells('0);
    tick();
    tick();
    chk("rst_state", bus.state, S_INI);
    chk("rst_arr", bus.arr, '0);
    chk("rst_lines", bus.lines, 8'd0);
    chk("rst_gen", bus.gen_flag, 1'b0);
    chk("rst_over", bus.game_over, 1'b0);

    Reset = 1'b0;
    chk("rel_state", bus.state, S_INI);
    tick();
    chk("rel_gen_state", bus.state, S_GEN);
    chk("rel_gen_flag", bus.gen_flag, 1'b1);
    tick();
    chk("rel_play", bus.state, S_PLAY);
    chk("rel_gen_drop", bus.gen_flag, 1'b0);

    // Ack and top_flag outside their states do nothing
    bus.Ack = 1'b1;
    bus.top_flag = 1'b1;
    tick();
    chk("ack_ignored", bus.state, S_PLAY);
    bus.Ack = 1'b0;
    bus.top_flag = 1'b0;

    // Four cells on row 0, no clear
    exp_b = '0;
    for (int x = 0; x < 4; x++) exp_b = put(exp_b, x, 0);
    land("A", {4'd0, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0}, 1'b0, cyc, lock_b);
    chk("A_lock_arr", lock_b, exp_b);
    chk("A_cycles", cyc, 15);
    chk("A_arr", bus.arr, exp_b);
    chk("A_lines", bus.lines, 8'd0);

    // Duplicate coordinate
    exp_b = put(exp_b, 4, 0);
    exp_b = put(exp_b, 5, 0);
    exp_b = put(exp_b, 4, 1);
    land("B", {4'd4, 4'd0, 4'd5, 4'd0, 4'd4, 4'd1, 4'd4, 4'd1}, 1'b0, cyc, lock_b);
    chk("B_cycles", cyc, 15);
    chk("B_arr", bus.arr, exp_b);

    // Completing row 0 clears it and drops (4,1)
    for (int x = 6; x < 10; x++) exp_b = put(exp_b, x, 0);
    land("C", {4'd6, 4'd0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd9, 4'd0}, 1'b0, cyc, lock_b);
    chk("C_lock_arr", lock_b, exp_b);
    chk("C_cycles", cyc, 17);
    exp_b = put('0, 4, 0);
    chk("C_arr", bus.arr, exp_b);
    chk("C_lines", bus.lines, 8'd1);

    // Build rows 0 and 1 with x=0..7; last landing has an out-of-range cell
    land("D1", {4'd0, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0}, 1'b0, cyc, lock_b);
    chk("D1_cycles", cyc, 15);
    land("D2", {4'd5, 4'd0, 4'd6, 4'd0, 4'd7, 4'd0, 4'd0, 4'd1}, 1'b0, cyc, lock_b);
    land("D3", {4'd1, 4'd1, 4'd2, 4'd1, 4'd3, 4'd1, 4'd4, 4'd1}, 1'b0, cyc, lock_b);
    land("D4", {4'd5, 4'd1, 4'd6, 4'd1, 4'd7, 4'd1, 4'd12, 4'd5}, 1'b0, cyc, lock_b);
    exp_b = '0;
    for (int x = 0; x < 8; x++) begin
      exp_b = put(exp_b, x, 0);
      exp_b = put(exp_b, x, 1);
    end
    chk("D4_arr", bus.arr, exp_b);
    chk("D4_cycles", cyc, 15);

    // One landing completes two rows: two clears at row 0
    land("E", {4'd8, 4'd0, 4'd9, 4'd0, 4'd8, 4'd1, 4'd9, 4'd1}, 1'b0, cyc, lock_b);
    chk("E_cycles", cyc, 19);
    chk("E_arr", bus.arr, '0);
    chk("E_lines", bus.lines, 8'd3);

    // bottom_flag held high through GEN into PLAY
    land("F", {4'd2, 4'd3, 4'd2, 4'd3, 4'd2, 4'd3, 4'd2, 4'd3}, 1'b1, cyc, lock_b);
    chk("F_cycles", cyc, 15);
    tick();
    chk("F_play", bus.state, S_PLAY);
    for (int k = 0; k < 4; k++) tick();
    chk("F_held_no_lock", bus.state, S_PLAY);
    bus.bottom_flag = 1'b0;
    tick();
    chk("F_fall_play", bus.state, S_PLAY);
    land("G", {4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3}, 1'b0, cyc, lock_b);
    chk("G_cycles", cyc, 15);
    exp_b = put(put('0, 2, 3), 3, 3);
    chk("G_arr", bus.arr, exp_b);

    // Landing touching the top ends the game
    wait_play("H_play");
    set_cells({4'd0, 4'd11, 4'd1, 4'd11, 4'd15, 4'd15, 4'd9, 4'd11});
    bus.top_flag    = 1'b1;
    bus.bottom_flag = 1'b1;
    tick();
    chk("H_lock", bus.state, S_LOCK);
    tick();
    bus.top_flag = 1'b0;
    exp_b = put(put(put(exp_b, 0, 11), 1, 11), 9, 11);
    chk("H_over", bus.state, S_OVER);
    chk("H_game_over", bus.game_over, 1'b1);
    chk("H_gen", bus.gen_flag, 1'b0);
    chk("H_arr", bus.arr, exp_b);
    bus.bottom_flag = 1'b0;
    tick();
    bus.bottom_flag = 1'b1;
    tick();
    tick();
    chk("H_hold_state", bus.state, S_OVER);
    chk("H_hold_arr", bus.arr, exp_b);
    chk("H_hold_lines", bus.lines, 8'd3);
    chk("H_hold_gen", bus.gen_flag, 1'b0);
    bus.bottom_flag = 1'b0;
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    chk("H_ack_ini", bus.state, S_INI);
    chk("H_ack_arr", bus.arr, '0);
    chk("H_ack_lines", bus.lines, 8'd0);
    chk("H_ack_over", bus.game_over, 1'b0);
    tick();
    chk("H_gen_again", bus.gen_flag, 1'b1);

    // Reset during LOCK leaves nothing behind
    wait_play("I_play");
    set_cells({4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd6, 4'd6});
    bus.bottom_flag = 1'b1;
    tick();
    chk("I_lock", bus.state, S_LOCK);
    #2;
    Reset = 1'b1;
    #1;
    chk("I_async_state", bus.state, S_INI);
    bus.bottom_flag = 1'b0;
    tick();
    chk("I_arr", bus.arr, '0);
    chk("I_gen_in_rst", bus.gen_flag, 1'b0);
    Reset = 1'b0;
    tick();
    chk("I_gen", bus.gen_flag, 1'b1);
    tick();
    chk("I_play_after", bus.state, S_PLAY);
    chk("I_arr_after", bus.arr, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_array.md
BOARD_ARRAY -- requirements
Module: board_array

Interface
REQ-001 The module SHALL have no parameters; the board is fixed at 10 columns (x 0..9) by 12 rows (y 0..11, row 0 at the bottom).
REQ-002 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 bottom_flag  input  1  piece-landed level from the falling-piece generator; high while that generator waits.
REQ-005 top_flag  input  1  landed piece touched row 11; sampled only in LOCK.
REQ-006 Ack  input  1  user acknowledge; used only in OVER.
REQ-007 x1,y1,x2,y2,x3,y3,x4,y4  input  4 each  cell coordinates of the landed piece.
REQ-008 arr  output  [9:0][11:0]  board occupancy; arr[x][y]=1 means the cell is filled.
REQ-009 gen_flag  output  1  request for a new piece, decoded as state==GEN.
REQ-010 game_over  output  1  decoded as state==OVER.
REQ-011 lines  output  8  count of cleared rows.
REQ-012 state  output  7  one-hot state: INI=0000001, GEN=0000010, PLAY=0000100, LOCK=0001000, SCAN=0010000, SHIFT=0100000, OVER=1000000.

Function
REQ-013 The module SHALL hold an internal 4-bit row index r and a 1-bit register bf_d that captures bottom_flag every cycle in every state.
REQ-014 INI: clear r to 0; go to GEN on the next edge unconditionally.
REQ-015 GEN: assert gen_flag for exactly this one cycle; go to PLAY.
REQ-016 PLAY: on a rising edge of bottom_flag (bottom_flag=1 and bf_d=0), go to LOCK; otherwise stay. A bottom_flag level that is already high without a rising edge SHALL NOT trigger LOCK.
REQ-017 LOCK: in a single cycle, set arr[xi][yi]=1 for each of the four cells whose xi<=9 and yi<=11.
REQ-018 LOCK: cells with out-of-range coordinates SHALL be skipped with no other effect.
REQ-019 LOCK: duplicate coordinates SHALL be harmless.
REQ-020 LOCK transitions: if top_flag=1, go to OVER; else set r=0 and go to SCAN.
REQ-021 SCAN: if all 10 cells of row r are 1, go to SHIFT.
REQ-022 SCAN: else if r==11, go to GEN.
REQ-023 SCAN: else increment r and stay in SCAN.
REQ-024 SHIFT: in one cycle, for every x and every y>=r with y<11, set arr[x][y] to arr[x][y+1]; set row 11 to all zeros; leave rows below r unchanged.
REQ-025 SHIFT: increment lines, saturating at 255; go to SCAN with r unchanged, so a newly dropped full row is re-examined.
REQ-026 OVER: hold arr and lines. On Ack=1, clear arr to all zeros, clear lines to 0, and go to INI.
REQ-027 Ack in any state other than OVER SHALL be ignored.
REQ-028 bottom_flag and top_flag outside their sampling states SHALL be ignored.
REQ-029 Latency, rising bottom_flag to cells visible in arr: 2 edges (PLAY->LOCK, LOCK writes).
REQ-030 Latency, no-clear landing to gen_flag: 2+12+1 cycles (LOCK, SCAN r=0..11, GEN).
REQ-031 Each cleared row SHALL add exactly 2 cycles (SCAN+SHIFT) to the no-clear latency.

Reset
REQ-032 Reset SHALL asynchronously force: state=INI, arr=all zeros, lines=0, r=0, bf_d=0, gen_flag=0, game_over=0.
REQ-033 Reset asserted mid-LOCK, mid-SCAN or mid-SHIFT SHALL abandon the operation with no partial write surviving.
REQ-034 After Reset deasserts, the first gen_flag pulse SHALL occur in the second cycle (INI, then GEN).

Verification
REQ-035 Reset release -> state INI then GEN; gen_flag high exactly one cycle; arr=0; lines=0.
REQ-036 In PLAY, bottom_flag rises with cells (0,0),(1,0),(2,0),(3,0), top_flag=0 -> those 4 bits set; no clear; gen_flag pulses 15 cycles after LOCK entry; lines=0.
REQ-037 Row 0 preloaded with x=0..5, plus (4,1); land cells (6,0),(7,0),(8,0),(9,0) -> row 0 cleared; (4,1) moves to (4,0); lines=1; gen_flag after 17 cycles.
REQ-038 Rows 0 and 1 completed by a single landing -> two SHIFTs at r=0 (r not advanced); both rows empty afterwards; lines=2.
REQ-039 Landing with top_flag=1 -> OVER, game_over=1, gen_flag stays 0; Ack=1 -> arr=0, lines=0, INI then GEN.
REQ-040 bottom_flag held high across GEN into PLAY -> no second LOCK until bottom_flag falls and rises again.
